// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERR      = 2'd3
  } state_t;

  // Register $zero never creates a load-use dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Per-cycle pipeline control word.
  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_we;
    logic idex_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET  = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b1, idex_we: 1'b0, idex_flush: 1'b1};
  localparam ctrl_t CTRL_FREEZE = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0, idex_we: 1'b0, idex_flush: 1'b0};
  localparam ctrl_t CTRL_BRANCH = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1, idex_we: 1'b1, idex_flush: 1'b1};
  localparam ctrl_t CTRL_JUMP   = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1, idex_we: 1'b1, idex_flush: 1'b0};
  localparam ctrl_t CTRL_BUBBLE = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0, idex_we: 1'b1, idex_flush: 1'b1};
  localparam ctrl_t CTRL_NORMAL = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0, idex_we: 1'b1, idex_flush: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus between the datapath (master) and the controller (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_memr;
  logic [REG_W-1:0] ex_rt;
  logic             id_jump;
  logic             br_taken;
  logic             mem_busy;

  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_we;
  logic             idex_flush;
  logic             hz_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memr, ex_rt, id_jump, br_taken, mem_busy,
    input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush, hz_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memr, ex_rt, id_jump, br_taken, mem_busy,
    output pc_we, ifid_we, ifid_flush, idex_we, idex_flush, hz_err, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between ID sources and the ID/EX load target.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             i_ex_memr,
  input  logic [REG_W-1:0] i_ex_rt,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_uses_rt,
  output logic             o_lu
);

  logic w_rs_hit;
  logic w_rt_hit;
  logic w_nonzero;

  assign w_nonzero = (i_ex_rt != REG_W'(REG_ZERO));
  assign w_rs_hit  = (i_ex_rt == i_id_rs);
  assign w_rt_hit  = i_id_uses_rt & (i_ex_rt == i_id_rt);
  assign o_lu      = i_ex_memr & w_nonzero & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch/jump flushes,
// memory-busy freeze with timeout, and saturating perf counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int BR_PENALTY = 1,
  parameter int WAIT_MAX   = 15,
  parameter int CNT_W      = 16
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam logic [2:0]       FCNT_INIT = 3'(BR_PENALTY - 1);
  localparam logic [7:0]       WCNT_MAX  = 8'(WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  state_t           r_state;
  logic [2:0]       r_fcnt;
  logic [7:0]       r_wcnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             r_hz_err;

  state_t     w_state_nxt;
  logic [2:0] w_fcnt_nxt;
  logic [7:0] w_wcnt_nxt;
  ctrl_t      w_ctrl;
  logic       w_flush_evt;
  logic       w_err_set;
  logic       w_do_run;
  logic       w_do_flush;
  logic       w_lu;

  load_use_detect #(
    .REG_W(REG_W)
  ) u_lu (
    .i_ex_memr   (bus.ex_memr),
    .i_ex_rt     (bus.ex_rt),
    .i_id_rs     (bus.id_rs),
    .i_id_rt     (bus.id_rt),
    .i_id_uses_rt(bus.id_uses_rt),
    .o_lu        (w_lu)
  );

  // Next-state and control decode; MEM_WAIT exit reuses the RUN/FLUSH paths
  // in the same cycle so the freeze is not repeated.
  always_comb begin
    w_ctrl      = CTRL_FREEZE;
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    w_wcnt_nxt  = r_wcnt;
    w_flush_evt = 1'b0;
    w_err_set   = 1'b0;
    w_do_run    = 1'b0;
    w_do_flush  = 1'b0;

    unique case (r_state)
      ST_RUN: begin
        if (bus.mem_busy) begin
          w_state_nxt = ST_MEM_WAIT;
          w_wcnt_nxt  = 8'd1;
        end else begin
          w_do_run = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (bus.mem_busy) begin
          w_state_nxt = ST_MEM_WAIT;
          w_wcnt_nxt  = 8'd1;
        end else begin
          w_do_flush = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.mem_busy) begin
          if (r_wcnt == WCNT_MAX) begin
            w_err_set   = 1'b1;
            w_state_nxt = ST_ERR;
          end else begin
            w_wcnt_nxt = r_wcnt + 8'd1;
          end
        end else if (r_fcnt != 3'd0) begin
          w_do_flush = 1'b1;
        end else begin
          w_do_run = 1'b1;
        end
      end
      ST_ERR: begin
        w_state_nxt = ST_ERR;
      end
    endcase

    if (w_do_flush) begin
      w_ctrl      = CTRL_BRANCH;
      w_fcnt_nxt  = r_fcnt - 3'd1;
      w_state_nxt = (r_fcnt == 3'd1) ? ST_RUN : ST_FLUSH;
    end

    if (w_do_run) begin
      w_state_nxt = ST_RUN;
      if (bus.br_taken) begin
        w_ctrl      = CTRL_BRANCH;
        w_flush_evt = 1'b1;
        if (BR_PENALTY > 1) begin
          w_state_nxt = ST_FLUSH;
          w_fcnt_nxt  = FCNT_INIT;
        end
      end else if (bus.id_jump) begin
        w_ctrl      = CTRL_JUMP;
        w_flush_evt = 1'b1;
      end else if (w_lu) begin
        w_ctrl = CTRL_BUBBLE;
      end else begin
        w_ctrl = CTRL_NORMAL;
      end
    end

    if (rst) begin
      w_ctrl = CTRL_RESET;
    end
  end

  // State, wait/flush counters, sticky error and saturating perf counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_fcnt      <= '0;
      r_wcnt      <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_hz_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_fcnt   <= w_fcnt_nxt;
      r_wcnt   <= w_wcnt_nxt;
      r_hz_err <= r_hz_err | w_err_set;
      if (!w_ctrl.pc_we && (r_stall_cnt != CNT_SAT)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush_evt && (r_flush_cnt != CNT_SAT)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign bus.pc_we      = w_ctrl.pc_we;
  assign bus.ifid_we    = w_ctrl.ifid_we;
  assign bus.ifid_flush = w_ctrl.ifid_flush;
  assign bus.idex_we    = w_ctrl.idex_we;
  assign bus.idex_flush = w_ctrl.idex_flush;
  assign bus.hz_err     = r_hz_err;
  assign bus.stall_cnt  = r_stall_cnt;
  assign bus.flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl with a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int REG_W   = 5;
  localparam int BRP     = 3;
  localparam int WMAX    = 15;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Control vector order: {pc_we, ifid_we, ifid_flush, idex_we, idex_flush}
  localparam logic [4:0] V_RESET  = 5'b00101;
  localparam logic [4:0] V_FREEZE = 5'b00000;
  localparam logic [4:0] V_BRANCH = 5'b11111;
  localparam logic [4:0] V_JUMP   = 5'b11110;
  localparam logic [4:0] V_BUBBLE = 5'b00011;
  localparam logic [4:0] V_NORMAL = 5'b11010;

  typedef struct {
    bit       rst;
    bit [4:0] rs;
    bit [4:0] rt;
    bit       uses_rt;
    bit       memr;
    bit [4:0] ex_rt;
    bit       jump;
    bit       br;
    bit       busy;
  } stim_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(
    .REG_W     (REG_W),
    .BR_PENALTY(BRP),
    .WAIT_MAX  (WMAX),
    .CNT_W     (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [4:0] obs;
  assign obs = {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_we, bus.idex_flush};

  int errors = 0;
  int checks = 0;

  // Reference model: committed state and pending next state.
  int m_err = 0, m_flush_left = 0, m_waited = 0, m_stall = 0, m_flush = 0;
  int n_err, n_flush_left, n_waited, n_stall, n_flush;
  bit pending = 0;
  logic [4:0] e_ctrl;

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  task automatic apply(input stim_t s);
    bit lu;
    @(negedge clk);
    if (pending) begin
      m_err = n_err; m_flush_left = n_flush_left; m_waited = n_waited;
      m_stall = n_stall; m_flush = n_flush;
    end
    rst            = s.rst;
    bus.id_rs      = s.rs;
    bus.id_rt      = s.rt;
    bus.id_uses_rt = s.uses_rt;
    bus.ex_memr    = s.memr;
    bus.ex_rt      = s.ex_rt;
    bus.id_jump    = s.jump;
    bus.br_taken   = s.br;
    bus.mem_busy   = s.busy;

    lu = s.memr && (s.ex_rt != 0) && ((s.ex_rt == s.rs) || (s.uses_rt && s.ex_rt == s.rt));
    n_err = m_err; n_flush_left = m_flush_left; n_waited = m_waited;
    n_stall = m_stall; n_flush = m_flush;
    if (s.rst) begin
      e_ctrl = V_RESET;
      n_err = 0; n_flush_left = 0; n_waited = 0; n_stall = 0; n_flush = 0;
    end else if (m_err != 0) begin
      e_ctrl  = V_FREEZE;
      n_stall = sat(m_stall);
    end else if (s.busy) begin
      e_ctrl   = V_FREEZE;
      n_waited = m_waited + 1;
      if (n_waited > WMAX) n_err = 1;
      n_stall  = sat(m_stall);
    end else begin
      n_waited = 0;
      if (m_flush_left > 0) begin
        e_ctrl = V_BRANCH;
        n_flush_left = m_flush_left - 1;
      end else if (s.br) begin
        e_ctrl = V_BRANCH;
        n_flush = sat(m_flush);
        n_flush_left = BRP - 1;
      end else if (s.jump) begin
        e_ctrl = V_JUMP;
        n_flush = sat(m_flush);
      end else if (lu) begin
        e_ctrl = V_BUBBLE;
        n_stall = sat(m_stall);
      end else begin
        e_ctrl = V_NORMAL;
      end
    end
    pending = 1;
    #1;
  endtask

  task automatic do_reset();
    stim_t s;
    s = idle();
    s.rst = 1;
    apply(s);
  endtask

  task automatic test_reset();
    stim_t s;
    do_reset();
    checks++;
    if (obs !== V_RESET) begin errors++; $display("FAIL reset_ctrl got %b want %b", obs, V_RESET); end
    s = idle();
    apply(s);
    checks++;
    if (obs !== V_NORMAL) begin errors++; $display("FAIL reset_exit_ctrl got %b want %b", obs, V_NORMAL); end
    checks++;
    if (bus.stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", bus.stall_cnt); end
    checks++;
    if (bus.flush_cnt !== 4'd0) begin errors++; $display("FAIL reset_flush got %0d want 0", bus.flush_cnt); end
    checks++;
    if (bus.hz_err !== 1'b0) begin errors++; $display("FAIL reset_hzerr got %b want 0", bus.hz_err); end
  endtask

  task automatic test_load_use();
    stim_t s;
    do_reset();
    s = idle(); s.memr = 1; s.ex_rt = 5'd8; s.rs = 5'd8;
    apply(s);
    checks++;
    if (obs !== V_BUBBLE) begin errors++; $display("FAIL lu_bubble got %b want %b", obs, V_BUBBLE); end
    s = idle(); s.rs = 5'd8;
    apply(s);
    checks++;
    if (obs !== V_NORMAL) begin errors++; $display("FAIL lu_release got %b want %b", obs, V_NORMAL); end
    checks++;
    if (bus.stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_stall got %0d want 1", bus.stall_cnt); end
    s = idle(); s.memr = 1; s.ex_rt = 5'd7; s.rt = 5'd7; s.rs = 5'd1; s.uses_rt = 1;
    apply(s);
    checks++;
    if (obs !== V_BUBBLE) begin errors++; $display("FAIL lu_rt got %b want %b", obs, V_BUBBLE); end
    s.uses_rt = 0;
    apply(s);
    checks++;
    if (obs !== V_NORMAL) begin errors++; $display("FAIL lu_rt_unused got %b want %b", obs, V_NORMAL); end
  endtask

  task automatic test_zero_reg();
    stim_t s;
    do_reset();
    s = idle(); s.memr = 1; s.uses_rt = 1;
    apply(s);
    checks++;
    if (obs !== V_NORMAL) begin errors++; $display("FAIL zero_reg got %b want %b", obs, V_NORMAL); end
  endtask

  task automatic test_branch_penalty();
    stim_t s;
    do_reset();
    s = idle(); s.br = 1;
    apply(s);
    checks++;
    if (obs !== V_BRANCH) begin errors++; $display("FAIL br_cycle0 got %b want %b", obs, V_BRANCH); end
    s = idle();
    for (int i = 1; i < BRP; i++) begin
      apply(s);
      checks++;
      if (obs !== V_BRANCH) begin errors++; $display("FAIL br_cycle%0d got %b want %b", i, obs, V_BRANCH); end
    end
    apply(s);
    checks++;
    if (obs !== V_NORMAL) begin errors++; $display("FAIL br_done got %b want %b", obs, V_NORMAL); end
    checks++;
    if (bus.flush_cnt !== 4'd1) begin errors++; $display("FAIL br_flush_cnt got %0d want 1", bus.flush_cnt); end
  endtask

  task automatic test_mem_wait_flush();
    stim_t s;
    do_reset();
    s = idle(); s.br = 1;
    apply(s);
    s = idle(); s.busy = 1;
    for (int i = 0; i < 4; i++) begin
      apply(s);
      checks++;
      if (obs !== V_FREEZE) begin errors++; $display("FAIL mw_freeze%0d got %b want %b", i, obs, V_FREEZE); end
    end
    s = idle();
    for (int i = 0; i < 2; i++) begin
      apply(s);
      checks++;
      if (obs !== V_BRANCH) begin errors++; $display("FAIL mw_resume%0d got %b want %b", i, obs, V_BRANCH); end
    end
    apply(s);
    checks++;
    if (obs !== V_NORMAL) begin errors++; $display("FAIL mw_done got %b want %b", obs, V_NORMAL); end
    checks++;
    if (bus.stall_cnt !== 4'd4) begin errors++; $display("FAIL mw_stall got %0d want 4", bus.stall_cnt); end
    checks++;
    if (bus.flush_cnt !== 4'd1) begin errors++; $display("FAIL mw_flush got %0d want 1", bus.flush_cnt); end
  endtask

  task automatic test_wait_timeout();
    stim_t s;
    do_reset();
    s = idle(); s.busy = 1;
    for (int i = 0; i < WMAX; i++) apply(s);
    s = idle();
    apply(s);
    checks++;
    if (bus.hz_err !== 1'b0) begin errors++; $display("FAIL wait_limit_hzerr got %b want 0", bus.hz_err); end
    checks++;
    if (obs !== V_NORMAL) begin errors++; $display("FAIL wait_limit_ctrl got %b want %b", obs, V_NORMAL); end
    s = idle(); s.busy = 1;
    for (int i = 0; i < WMAX + 1; i++) apply(s);
    s = idle(); s.br = 1;
    apply(s);
    checks++;
    if (bus.hz_err !== 1'b1) begin errors++; $display("FAIL wait_err_hzerr got %b want 1", bus.hz_err); end
    checks++;
    if (obs !== V_FREEZE) begin errors++; $display("FAIL wait_err_freeze got %b want %b", obs, V_FREEZE); end
    checks++;
    if (bus.stall_cnt !== 4'(CNT_MAX)) begin errors++; $display("FAIL stall_sat got %0d want %0d", bus.stall_cnt, CNT_MAX); end
    do_reset();
    s = idle();
    apply(s);
    checks++;
    if (obs !== V_NORMAL) begin errors++; $display("FAIL err_rst_ctrl got %b want %b", obs, V_NORMAL); end
    checks++;
    if (bus.hz_err !== 1'b0 || bus.stall_cnt !== 4'd0) begin
      errors++; $display("FAIL err_rst_regs got hz=%b stall=%0d want hz=0 stall=0", bus.hz_err, bus.stall_cnt);
    end
  endtask

  task automatic test_priority();
    stim_t s;
    do_reset();
    s = idle(); s.br = 1; s.jump = 1; s.memr = 1; s.ex_rt = 5'd3; s.rs = 5'd3;
    apply(s);
    checks++;
    if (obs !== V_BRANCH) begin errors++; $display("FAIL prio_ctrl got %b want %b", obs, V_BRANCH); end
    s = idle();
    apply(s);
    checks++;
    if (bus.flush_cnt !== 4'd1) begin errors++; $display("FAIL prio_flush got %0d want 1", bus.flush_cnt); end
  endtask

  task automatic test_flush_saturation();
    stim_t s;
    do_reset();
    s = idle(); s.jump = 1;
    for (int i = 0; i < CNT_MAX + 5; i++) begin
      apply(s);
      checks++;
      if (obs !== V_JUMP) begin errors++; $display("FAIL jump%0d got %b want %b", i, obs, V_JUMP); end
    end
    s = idle();
    apply(s);
    checks++;
    if (bus.flush_cnt !== 4'(CNT_MAX)) begin errors++; $display("FAIL flush_sat got %0d want %0d", bus.flush_cnt, CNT_MAX); end
  endtask

  task automatic test_random();
    stim_t s;
    int burst;
    burst = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      s = idle();
      s.rst     = ($urandom_range(0, 99) == 0);
      s.rs      = 5'($urandom_range(0, 3));
      s.rt      = 5'($urandom_range(0, 3));
      s.ex_rt   = 5'($urandom_range(0, 3));
      s.uses_rt = ($urandom_range(0, 1) == 1);
      s.memr    = ($urandom_range(0, 2) == 0);
      s.jump    = ($urandom_range(0, 7) == 0);
      s.br      = ($urandom_range(0, 7) == 0);
      if (burst > 0) begin
        s.busy = 1;
        burst--;
      end else if ($urandom_range(0, 11) == 0) begin
        s.busy = 1;
        burst = $urandom_range(0, 19);
      end
      apply(s);
      checks++;
      if (obs !== e_ctrl) begin errors++; $display("FAIL rnd_ctrl cyc=%0d got %b want %b", i, obs, e_ctrl); end
      checks++;
      if (bus.stall_cnt !== 4'(m_stall)) begin errors++; $display("FAIL rnd_stall cyc=%0d got %0d want %0d", i, bus.stall_cnt, m_stall); end
      checks++;
      if (bus.flush_cnt !== 4'(m_flush)) begin errors++; $display("FAIL rnd_flush cyc=%0d got %0d want %0d", i, bus.flush_cnt, m_flush); end
      checks++;
      if (bus.hz_err !== 1'(m_err)) begin errors++; $display("FAIL rnd_hzerr cyc=%0d got %b want %0d", i, bus.hz_err, m_err); end
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.id_rs      = '0;
    bus.id_rt      = '0;
    bus.id_uses_rt = 1'b0;
    bus.ex_memr    = 1'b0;
    bus.ex_rt      = '0;
    bus.id_jump    = 1'b0;
    bus.br_taken   = 1'b0;
    bus.mem_busy   = 1'b0;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch_penalty();
    test_mem_wait_flush();
    test_wait_timeout();
    test_priority();
    test_flush_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
